// File: rtl/sevenseg_pkg.sv
// Shared state type, frame geometry and segment bit positions for the
// seven-segment shift-register driver.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  localparam int FRAME_BITS = 8;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Assembles the 8-bit frame from the pattern and decimal point, optionally
  // inverted for common-anode displays.
  function automatic logic [FRAME_BITS-1:0] frame_word(
    input logic [6:0] seg,
    input logic       dp,
    input logic       invert
  );
    logic [FRAME_BITS-1:0] w;
    w         = '0;
    w[SEG_A]  = seg[0];
    w[SEG_B]  = seg[1];
    w[SEG_C]  = seg[2];
    w[SEG_D]  = seg[3];
    w[SEG_E]  = seg[4];
    w[SEG_F]  = seg[5];
    w[SEG_G]  = seg[6];
    w[SEG_DP] = dp;
    return w ^ {FRAME_BITS{invert}};
  endfunction

endpackage

// File: rtl/sevenseg_tick_div.sv
// Loadable down-counter that times each shift/latch phase; tc is high on the
// last cycle of a phase.
module sevenseg_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic tc
);

  localparam logic [7:0] RELOAD_VALUE = 8'(CLK_DIV - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (reload) begin
      count <= RELOAD_VALUE;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign tc = (count == 8'd0);

endmodule

// File: rtl/sevenseg_shift_driver.sv
// Serialises a seven-segment pattern plus decimal point into a 74HC595-style
// shift register, resending only when the pattern changes or a refresh is asked for.
module sevenseg_shift_driver
  import sevenseg_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int INVERT    = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segments_i,
  input  logic       dp_i,
  input  logic       load_i,
  output logic       sr_data_o,
  output logic       sr_clk_o,
  output logic       sr_latch_o,
  output logic       busy_o,
  output logic       frame_done_o
);

  state_t                  state;
  state_t                  next_state;
  logic [FRAME_BITS-1:0]   word;
  logic [FRAME_BITS-1:0]   shift_word;
  logic [FRAME_BITS-1:0]   shadow;
  logic [2:0]              bit_cnt;
  logic                    force_flag;
  logic                    pending;
  logic                    request;
  logic                    capture;
  logic                    advance;
  logic                    finish;
  logic                    tc;
  logic                    reload;
  logic                    cur_bit;
  logic                    done_flag;

  assign word    = frame_word(segments_i, dp_i, INVERT != 0);
  assign request = (word != shadow) || load_i || force_flag || pending;
  assign reload  = (next_state != state);
  assign cur_bit = (MSB_FIRST != 0) ? shift_word[3'd7 - bit_cnt] : shift_word[bit_cnt];

  sevenseg_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .rst   (rst),
    .reload(reload),
    .tc    (tc)
  );

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          next_state = SHIFT_LO;
          capture    = 1'b1;
        end
      end
      SHIFT_LO: begin
        if (tc) next_state = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tc) begin
          if (bit_cnt == 3'd7) begin
            next_state = LATCH;
          end else begin
            next_state = SHIFT_LO;
            advance    = 1'b1;
          end
        end
      end
      LATCH: begin
        if (tc) begin
          next_state = IDLE;
          finish     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The force flag starts set so that a full frame always follows reset,
  // even when the pattern equals the cleared shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift_word <= '0;
      shadow     <= '0;
      bit_cnt    <= '0;
      force_flag <= 1'b1;
      pending    <= 1'b0;
    end else begin
      state <= next_state;
      if (capture) begin
        shift_word <= word;
        shadow     <= word;
        bit_cnt    <= '0;
        force_flag <= 1'b0;
        pending    <= 1'b0;
      end else begin
        if (advance) bit_cnt <= bit_cnt + 3'd1;
        if (load_i && state != IDLE) pending <= 1'b1;
      end
    end
  end

  // Pins are registered decodes of the state, so they trail it by one cycle;
  // frame_done is delayed an extra stage to stay aligned with the other pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_data_o    <= 1'b0;
      sr_clk_o     <= 1'b0;
      sr_latch_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_flag    <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      sr_data_o    <= (state == SHIFT_LO || state == SHIFT_HI) ? cur_bit : 1'b0;
      sr_clk_o     <= (state == SHIFT_HI);
      sr_latch_o   <= (state == LATCH);
      busy_o       <= (state != IDLE);
      done_flag    <= finish;
      frame_done_o <= done_flag;
    end
  end

endmodule

// File: tb/tb_sevenseg_shift_driver.sv
// Self-checking bench: four driver instances with different parameters share
// one stimulus; frames are decoded from the pins and compared to a word model.
module tb_sevenseg_shift_driver;

  localparam int NI = 4;
  localparam int DIVS [NI] = '{2, 2, 2, 1};
  localparam int INVS [NI] = '{0, 1, 0, 0};
  localparam int MSBS [NI] = '{1, 1, 0, 1};

  typedef struct packed {
    logic [6:0]  seg;
    logic        dp;
    logic        load;
    logic [31:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [6:0]    segments = 7'h00;
  logic          dp = 1'b0;
  logic          load = 1'b0;
  logic [NI-1:0] sr_data;
  logic [NI-1:0] sr_clk;
  logic [NI-1:0] sr_latch;
  logic [NI-1:0] busy;
  logic [NI-1:0] frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] hist [1024];

  logic       prev_clk [NI];
  logic       prev_latch [NI];
  logic [7:0] seq [NI];
  int         bits [NI];
  int         latch_len [NI];
  logic [7:0] latched [NI];
  int         latched_bits [NI];
  int         edges_total [NI] = '{default: 0};
  int         frames [NI] = '{default: 0};
  int         done_edge [NI] = '{default: 0};
  logic [7:0] last_seq [NI];
  int         base_frames [NI];

  always #5 clk = ~clk;

  sevenseg_shift_driver #(.CLK_DIV(2), .INVERT(0), .MSB_FIRST(1)) dut0 (
    .clk(clk), .rst(rst), .segments_i(segments), .dp_i(dp), .load_i(load),
    .sr_data_o(sr_data[0]), .sr_clk_o(sr_clk[0]), .sr_latch_o(sr_latch[0]),
    .busy_o(busy[0]), .frame_done_o(frame_done[0]));
  sevenseg_shift_driver #(.CLK_DIV(2), .INVERT(1), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .segments_i(segments), .dp_i(dp), .load_i(load),
    .sr_data_o(sr_data[1]), .sr_clk_o(sr_clk[1]), .sr_latch_o(sr_latch[1]),
    .busy_o(busy[1]), .frame_done_o(frame_done[1]));
  sevenseg_shift_driver #(.CLK_DIV(2), .INVERT(0), .MSB_FIRST(0)) dut2 (
    .clk(clk), .rst(rst), .segments_i(segments), .dp_i(dp), .load_i(load),
    .sr_data_o(sr_data[2]), .sr_clk_o(sr_clk[2]), .sr_latch_o(sr_latch[2]),
    .busy_o(busy[2]), .frame_done_o(frame_done[2]));
  sevenseg_shift_driver #(.CLK_DIV(1), .INVERT(0), .MSB_FIRST(1)) dut3 (
    .clk(clk), .rst(rst), .segments_i(segments), .dp_i(dp), .load_i(load),
    .sr_data_o(sr_data[3]), .sr_clk_o(sr_clk[3]), .sr_latch_o(sr_latch[3]),
    .busy_o(busy[3]), .frame_done_o(frame_done[3]));

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: the k-th bit on the wire, assembled so the first bit lands in bit 7.
  function automatic logic [7:0] expected_seq(input logic [7:0] raw, input int inv, input int msb);
    logic [7:0] w;
    logic [7:0] s;
    w = (inv != 0) ? ~raw : raw;
    for (int k = 0; k < 8; k++) s[7-k] = (msb != 0) ? w[7-k] : w[k];
    return s;
  endfunction

  always @(posedge clk) begin
    hist[cyc % 1024] = {dp, segments};
    cyc++;
  end

  // Pin-level decoder: rebuilds each frame from sr_clk rising edges and checks
  // it against the inputs present at the edge that must have sampled them.
  always @(negedge clk) begin
    int s;
    for (int g = 0; g < NI; g++) begin
      if (!rst) begin
        prev_clk[g]   = 1'b0;
        prev_latch[g] = 1'b0;
        bits[g]       = 0;
        latch_len[g]  = 0;
      end else begin
        if (sr_clk[g] && !prev_clk[g]) begin
          seq[g] = {seq[g][6:0], sr_data[g]};
          bits[g]++;
          edges_total[g]++;
        end
        if (sr_latch[g]) latch_len[g]++;
        if (sr_latch[g] && !prev_latch[g]) begin
          latched[g]      = seq[g];
          latched_bits[g] = bits[g];
          bits[g]         = 0;
        end
        if (!sr_latch[g] && prev_latch[g]) begin
          check_output($sformatf("latch_width[%0d]", g), latch_len[g], DIVS[g]);
          latch_len[g] = 0;
        end
        if (frame_done[g]) begin
          frames[g]++;
          done_edge[g] = cyc - 1;
          last_seq[g]  = latched[g];
          check_output($sformatf("bits_per_frame[%0d]", g), latched_bits[g], 8);
          s = (cyc - 1) - (1 + 17 * DIVS[g]);
          if (s >= 0)
            check_output($sformatf("frame_vs_model[%0d]", g), latched[g],
                         expected_seq(hist[s % 1024], INVS[g], MSBS[g]));
        end
        prev_clk[g]   = sr_clk[g];
        prev_latch[g] = sr_latch[g];
      end
    end
  end

  task automatic apply_stimulus(input logic [6:0] s, input logic d, input logic l, output int start);
    @(negedge clk);
    segments = s;
    dp       = d;
    load     = l;
    start    = cyc;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frames(input int inst, input int target, input int budget, input string name);
    int n = 0;
    while (frames[inst] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(name, int'(frames[inst] >= target), 1);
  endtask

  task automatic wait_frames_all(input int budget, input string name);
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      ok = 1'b1;
      for (int g = 0; g < NI; g++) if (frames[g] <= base_frames[g]) ok = 1'b0;
    end
    check_output(name, int'(ok), 1);
  endtask

  task automatic wait_edges(input int inst, input int target, input int budget, input string name);
    int n = 0;
    while (edges_total[inst] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(name, int'(edges_total[inst] >= target), 1);
  endtask

  task automatic check_quiet(input int cycles, input string name);
    int e0 [NI];
    int d = 0;
    for (int g = 0; g < NI; g++) e0[g] = edges_total[g];
    repeat (cycles) @(negedge clk);
    for (int g = 0; g < NI; g++) d += edges_total[g] - e0[g];
    check_output({name, "_edges"}, d, 0);
    check_output({name, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [7];
    int   start;
    int   busy_bad;
    int   rel;
    int   f0;
    int   e0;
    int   d1;
    int   n;

    vecs[0] = '{seg: 7'h06, dp: 1'b0, load: 1'b0, exp: {8'h06, 8'h60, 8'hF9, 8'h06}};
    vecs[1] = '{seg: 7'h4F, dp: 1'b1, load: 1'b0, exp: {8'hCF, 8'hF3, 8'h30, 8'hCF}};
    vecs[2] = '{seg: 7'h7F, dp: 1'b1, load: 1'b0, exp: {8'hFF, 8'hFF, 8'h00, 8'hFF}};
    vecs[3] = '{seg: 7'h00, dp: 1'b0, load: 1'b0, exp: {8'h00, 8'h00, 8'hFF, 8'h00}};
    vecs[4] = '{seg: 7'h6D, dp: 1'b0, load: 1'b0, exp: {8'h6D, 8'hB6, 8'h92, 8'h6D}};
    vecs[5] = '{seg: 7'h6D, dp: 1'b0, load: 1'b1, exp: {8'h6D, 8'hB6, 8'h92, 8'h6D}};
    vecs[6] = '{seg: 7'h3F, dp: 1'b0, load: 1'b0, exp: {8'h3F, 8'hFC, 8'hC0, 8'h3F}};

    segments = 7'b0111111;
    dp       = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_outputs", int'({sr_data, sr_clk, sr_latch, busy, frame_done}), 0);

    // Release reset with an unchanged pattern: the forced first frame.
    rst   = 1'b1;
    start = cyc;
    for (int g = 0; g < NI; g++) base_frames[g] = frames[g];
    busy_bad = 0;
    n = 0;
    while (frames[0] <= base_frames[0] && n < 80) begin
      @(negedge clk);
      n++;
      rel = cyc - 1 - start;
      if (rel >= 1 && rel <= 34 && !busy[0]) busy_bad++;
    end
    wait_frames_all(80, "first_frame_timeout");
    check_output("first_busy_gaps", busy_bad, 0);
    check_output("first_frame_bits", last_seq[0], 8'h3F);
    check_output("first_latency", done_edge[0] - start, 35);
    check_output("first_latency_div1", done_edge[3] - start, 18);
    check_output("first_inverted", last_seq[1], 8'hC0);
    check_output("first_lsb_first", last_seq[2], 8'hFC);

    check_quiet(300, "idle_hold");

    for (int i = 0; i < 7; i++) begin
      for (int g = 0; g < NI; g++) base_frames[g] = frames[g];
      apply_stimulus(vecs[i].seg, vecs[i].dp, vecs[i].load, start);
      wait_frames_all(120, $sformatf("vec%0d_timeout", i));
      for (int g = 0; g < NI; g++) begin
        check_output($sformatf("vec%0d_bits[%0d]", i, g), last_seq[g], vecs[i].exp[g*8 +: 8]);
        check_output($sformatf("vec%0d_latency[%0d]", i, g), done_edge[g] - start, 1 + 17 * DIVS[g]);
      end
      repeat (25) @(negedge clk);
    end
    check_quiet(100, "after_table");

    // Pattern changes during the third bit: frame in flight unchanged, new one back-to-back.
    f0 = frames[0];
    e0 = edges_total[0];
    apply_stimulus(7'h3F, 1'b0, 1'b1, start);
    wait_edges(0, e0 + 2, 60, "midframe_edges_timeout");
    n = 0;
    while (sr_clk[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    segments = 7'b0000110;
    wait_frames(0, f0 + 1, 100, "midframe_first_timeout");
    check_output("midframe_first_bits", last_seq[0], 8'h3F);
    d1 = done_edge[0];
    wait_frames(0, f0 + 2, 100, "midframe_second_timeout");
    check_output("midframe_second_bits", last_seq[0], 8'h06);
    check_output("back_to_back_spacing", done_edge[0] - d1, 35);
    check_quiet(100, "after_midframe");

    // Asynchronous reset after three bits, then the forced resend of the same word.
    e0 = edges_total[0];
    f0 = frames[0];
    apply_stimulus(7'h06, 1'b0, 1'b1, start);
    wait_edges(0, e0 + 3, 60, "reset_edges_timeout");
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_output("async_reset_outputs", int'({sr_data, sr_clk, sr_latch, busy, frame_done}), 0);
    f0 = frames[0];
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_frames(0, f0 + 1, 80, "reset_resend_timeout");
    check_output("reset_resend_bits", last_seq[0], 8'h06);
    repeat (60) @(negedge clk);
    check_output("reset_resend_count", frames[0] - f0, 1);

    // Two refresh requests while busy collapse into one extra frame.
    f0 = frames[0];
    apply_stimulus(7'h06, 1'b0, 1'b1, start);
    repeat (4) @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (200) @(negedge clk);
    check_output("load_while_busy_frames", frames[0] - f0, 2);

    // Random inputs and refreshes; every frame is checked by the decoder.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(15) == 0) begin
        segments = 7'($urandom);
        dp       = 1'($urandom);
      end
      load = ($urandom_range(39) == 0);
    end
    @(negedge clk);
    load = 1'b0;
    repeat (200) @(negedge clk);
    for (int g = 0; g < NI; g++)
      check_output($sformatf("random_final_word[%0d]", g), last_seq[g],
                   expected_seq({dp, segments}, INVS[g], MSBS[g]));
    check_quiet(100, "random_settle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
